product_accumulator: RTL

//  Downstream stage of the 32x32 signed multiplier. Accepts a stream of signed
//  64-bit products over a valid/ready handshake and sums them into a saturating

---
 rtl/product_accumulator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator
//  Description : Saturating signed accumulator for the product stream of the
//                32x32 signed multiplier. Terms arrive over valid/ready. A term
//                flagged in_last closes the sequence, and the total is then
//                held on the output until the consumer takes it.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1       rising-edge clock
//    rst         in   1       asynchronous active-high reset
//    in_valid    in   1       in_product / in_last are valid
//    in_ready    out  1       stage can take a product this cycle
//    in_product  in   PROD_W  signed product (two's complement)
//    in_last     in   1       final term of the sequence
//    acc_clear   in   1       synchronous abort of a sequence in progress
//    out_valid   out  1       finished total is presented
//    out_ready   in   1       consumer accepts the total
//    out_acc     out  ACC_W   signed saturated sum
//    out_count   out  CNT_W   accepted terms, saturating at all-ones
//    out_sat     out  1       sticky saturation flag for this sequence
//  ACC_W must be >= PROD_W.
// ============================================================================
module product_accumulator #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 64,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   input  logic              in_last,
   input  logic              acc_clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_sat
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state, state_nx;
   logic [ACC_W-1:0] acc, acc_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic             sat, sat_nx;
   // Holds in_ready low from reset until the first clock edge after release.
   logic             started;

   logic             accept;
   logic             clr_now;
   logic [ACC_W-1:0] base_acc;
   logic [CNT_W-1:0] base_cnt;
   logic             base_sat;
   logic [ACC_W:0]   prod_ext;
   logic [ACC_W:0]   sum;
   logic             ovf;
   logic [ACC_W-1:0] sum_sat;

   assign in_ready  = started && (state != HOLD);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == HOLD);
   assign out_acc   = acc;
   assign out_count = count;
   assign out_sat   = sat;

   // A clear in the same cycle as an accept makes the product the first term
   // of a fresh sequence, so the arithmetic starts from a zeroed base.
   assign clr_now  = acc_clear && (state != HOLD);
   assign base_acc = clr_now ? '0 : acc;
   assign base_cnt = clr_now ? '0 : count;
   assign base_sat = clr_now ? 1'b0 : sat;

   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign prod_ext = {{(ACC_W+1-PROD_W){in_product[PROD_W-1]}}, in_product};
   assign sum      = {base_acc[ACC_W-1], base_acc} + prod_ext;
   assign ovf      = sum[ACC_W] != sum[ACC_W-1];
   assign sum_sat  = !ovf        ? sum[ACC_W-1:0] :
                     sum[ACC_W]  ? MIN_NEG : MAX_POS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         count   <= '0;
         sat     <= 1'b0;
         started <= 1'b0;
      end else begin
         state   <= state_nx;
         acc     <= acc_nx;
         count   <= count_nx;
         sat     <= sat_nx;
         started <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      count_nx = count;
      sat_nx   = sat;
      case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_nx   = sum_sat;
               sat_nx   = base_sat | ovf;
               count_nx = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
               state_nx = in_last ? HOLD : ACCUM;
            end else if (clr_now) begin
               acc_nx   = '0;
               count_nx = '0;
               sat_nx   = 1'b0;
               state_nx = IDLE;
            end
         end
         HOLD: begin
            if (out_ready) begin
               acc_nx   = '0;
               count_nx = '0;
               sat_nx   = 1'b0;
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
